univ_shift_reg: RTL and testbench

- Parametrised successor to the 4-bit ECL-style universal shift register: WIDTH-bit register with load, two shift directions, hold, and rotate.
- Adds a burst sequencer that repeats a shift COUNT times, one bit per clock, with busy/done status.
- Used wherever datapath logic needs multi-bit shifts, for example the AR/BR/MQ-style shifters and normalisation loops.
- Bit numbering is big-endian: bit 0 is the MSB and bit WIDTH-1 is the LSB.

---
 rtl/univ_shift_reg.sv | 169 ++++++++++++++++
 tb/tb_univ_shift_reg.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register (bit 0 = MSB) with a counted burst sequencer.
// Optional arithmetic fill and overflow flag enabled by defining UNIV_SHIFT_ARITH_EN.
module univ_shift_reg #(
  parameter int WIDTH = 36,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       op,
  input  logic [0:WIDTH-1] d,
  input  logic             sin0,
  input  logic             sinN,
  input  logic             rot,
  input  logic             start,
  input  logic [CW-1:0]    count,
`ifdef UNIV_SHIFT_ARITH_EN
  input  logic             arith,
  output logic             ovf,
`endif
  output logic [0:WIDTH-1] q,
  output logic             sout0,
  output logic             soutN,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_SHIFT0 = 2'b01,
    OP_SHIFTN = 2'b10,
    OP_HOLD   = 2'b11
  } op_t;

  op_t              op_in;
  op_t              mode_reg, mode_next;
  op_t              cur_dir;
  logic [0:WIDTH-1] q_reg, q_next;
  logic [0:WIDTH-1] sh0, shn;
  logic [CW-1:0]    rem_reg, rem_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             rot_reg, rot_next;
  logic             cur_rot, cur_arith;
  logic             fill0, filln;
  logic             shift_en, load_en;

  assign op_in   = op_t'(op);
  // During a burst the latched mode drives the shifter; otherwise the live inputs do.
  assign cur_dir = busy_reg ? mode_reg : op_in;
  assign cur_rot = busy_reg ? rot_reg : rot;

`ifdef UNIV_SHIFT_ARITH_EN
  logic arith_reg, arith_next;
  logic ovf_reg, ovf_next;
  assign cur_arith = busy_reg ? arith_reg : arith;
`else
  assign cur_arith = 1'b0;
`endif

  assign fill0 = cur_rot ? q_reg[WIDTH-1] : (cur_arith ? q_reg[0] : sin0);
  assign filln = cur_rot ? q_reg[0] : (cur_arith ? 1'b0 : sinN);

  assign sh0[0]       = fill0;
  assign shn[WIDTH-1] = filln;
  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_sh0
      assign sh0[gi] = q_reg[gi-1];
    end
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shn
      assign shn[gi] = q_reg[gi+1];
    end
  endgenerate

  always_comb begin
    q_next     = q_reg;
    rem_next   = rem_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    mode_next  = mode_reg;
    rot_next   = rot_reg;
    shift_en   = 1'b0;
    load_en    = 1'b0;
`ifdef UNIV_SHIFT_ARITH_EN
    arith_next = arith_reg;
`endif
    if (busy_reg) begin
      // Remaining count is always at least 1 while busy, so it never wraps.
      shift_en = 1'b1;
      rem_next = rem_reg - CW'(1);
      if (rem_reg == CW'(1)) begin
        busy_next = 1'b0;
        done_next = 1'b1;
      end
    end else if (start && (op_in == OP_SHIFT0 || op_in == OP_SHIFTN)) begin
      if (count == '0) begin
        done_next = 1'b1;
      end else begin
        shift_en   = 1'b1;
        mode_next  = op_in;
        rot_next   = rot;
`ifdef UNIV_SHIFT_ARITH_EN
        arith_next = arith;
`endif
        rem_next   = count - CW'(1);
        busy_next  = (count != CW'(1));
        done_next  = (count == CW'(1));
      end
    end else begin
      case (op_in)
        OP_LOAD:              load_en  = 1'b1;
        OP_SHIFT0, OP_SHIFTN: shift_en = 1'b1;
        default:              ;
      endcase
    end
    if (load_en) begin
      q_next = d;
    end else if (shift_en) begin
      q_next = (cur_dir == OP_SHIFT0) ? sh0 : shn;
    end
  end

`ifdef UNIV_SHIFT_ARITH_EN
  always_comb begin
    ovf_next = ovf_reg;
    if (load_en) begin
      ovf_next = 1'b0;
    end else if (shift_en && cur_arith && cur_dir == OP_SHIFTN && shn[0] != q_reg[0]) begin
      ovf_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      arith_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      arith_reg <= arith_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign ovf = ovf_reg;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_reg    <= '0;
      rem_reg  <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      mode_reg <= OP_HOLD;
      rot_reg  <= 1'b0;
    end else begin
      q_reg    <= q_next;
      rem_reg  <= rem_next;
      busy_reg <= busy_next;
      done_reg <= done_next;
      mode_reg <= mode_next;
      rot_reg  <= rot_next;
    end
  end

  assign q     = q_reg;
  assign sout0 = q_reg[0];
  assign soutN = q_reg[WIDTH-1];
  assign busy  = busy_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Randomised and directed bench for univ_shift_reg (WIDTH=8, CW=4) against a numeric model.
// Exercises the arithmetic option too when UNIV_SHIFT_ARITH_EN is defined.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] op;
  logic [0:7] d;
  logic       sin0, sinN, rot, start;
  logic [3:0] count;
  logic       arith;
  logic [0:7] q;
  logic       sout0, soutN, busy, done;
`ifdef UNIV_SHIFT_ARITH_EN
  logic       ovf;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: register held as an integer whose weight-128 bit is spec bit 0.
  int         mq, mpend;
  logic       mdone, mrot, marith, movf;
  logic [1:0] mdir;

  univ_shift_reg #(.WIDTH(8), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .d(d), .sin0(sin0), .sinN(sinN),
    .rot(rot), .start(start), .count(count),
`ifdef UNIV_SHIFT_ARITH_EN
    .arith(arith), .ovf(ovf),
`endif
    .q(q), .sout0(sout0), .soutN(soutN), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int mshift(input int v, input logic [1:0] dir, input logic r, input logic a);
    int fill;
    if (dir == 2'b01) begin
      fill = r ? (v & 1) : (a ? ((v >> 7) & 1) : int'(sin0));
      return (v >> 1) | (fill << 7);
    end
    fill = r ? ((v >> 7) & 1) : (a ? 0 : int'(sinN));
    return ((v << 1) & 255) | fill;
  endfunction

  task automatic mapply(input logic [1:0] dir, input logic r, input logic a);
    int nq;
    nq = mshift(mq, dir, r, a);
    if (a && dir == 2'b10 && ((nq >> 7) & 1) != ((mq >> 7) & 1)) movf = 1'b1;
    mq = nq;
  endtask

  task automatic model_edge();
    logic nd;
    nd = 1'b0;
    if (!rst_n) begin
      mq = 0; mpend = 0; mdir = 2'b11; mrot = 1'b0; marith = 1'b0; movf = 1'b0;
    end else begin
      if (mpend > 0) begin
        mapply(mdir, mrot, marith);
        mpend--;
        nd = (mpend == 0);
      end else if (start && (op == 2'b01 || op == 2'b10)) begin
        if (count == 0) nd = 1'b1;
        else begin
          mdir = op; mrot = rot; marith = arith;
          mapply(op, rot, arith);
          mpend = int'(count) - 1;
          nd = (mpend == 0);
        end
      end else if (op == 2'b00) begin
        mq = int'(d);
        movf = 1'b0;
      end else if (op != 2'b11) begin
        mapply(op, rot, arith);
      end
    end
    mdone = nd;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("q", 32'(q), 32'(mq));
    chk("sout0", 32'(sout0), 32'((mq >> 7) & 1));
    chk("soutN", 32'(soutN), 32'(mq & 1));
    chk("busy", 32'(busy), 32'(mpend > 0));
    chk("done", 32'(done), 32'(mdone));
`ifdef UNIV_SHIFT_ARITH_EN
    chk("ovf", 32'(ovf), 32'(movf));
`endif
  endtask

  task automatic idle();
    op = 2'b11; start = 1'b0; rot = 1'b0; arith = 1'b0;
    sin0 = 1'b0; sinN = 1'b0; count = 4'd0; d = 8'h00;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;

    // Reset in the middle of a burst abandons it without a done pulse.
    op = 2'b00; d = 8'hFF; tick();
    op = 2'b10; start = 1'b1; count = 4'd5; tick();
    start = 1'b0; op = 2'b11; tick();
    rst_n = 1'b0; tick();
    chk("midrst_q", 32'(q), 32'h00);
    chk("midrst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst_nodone", 32'(done), 32'h0);
    end

    // Single-step shifts.
    op = 2'b00; d = 8'hA5; tick();
    op = 2'b01; sin0 = 1'b1; tick();
    chk("sh0_q", 32'(q), 32'hD2);
    chk("sh0_sout0", 32'(sout0), 32'h1);
    chk("sh0_soutN", 32'(soutN), 32'h0);
    op = 2'b10; sinN = 1'b0; tick();
    chk("shn_q", 32'(q), 32'hA4);

    // Rotate burst of 3; op changes during the burst are ignored.
    idle();
    op = 2'b00; d = 8'h81; tick();
    op = 2'b10; rot = 1'b1; start = 1'b1; count = 4'd3; tick();
    chk("rot_c1_busy", 32'(busy), 32'h1);
    chk("rot_c1_done", 32'(done), 32'h0);
    start = 1'b0; op = 2'b00; d = 8'h55; rot = 1'b0; tick();
    chk("rot_c2_busy", 32'(busy), 32'h1);
    tick();
    chk("rot_c3_q", 32'(q), 32'h0C);
    chk("rot_c3_busy", 32'(busy), 32'h0);
    chk("rot_c3_done", 32'(done), 32'h1);
    op = 2'b11; tick();
    chk("rot_c4_done", 32'(done), 32'h0);

    // count=0 then count=1 (accepted in the done cycle).
    op = 2'b01; start = 1'b1; count = 4'd0; tick();
    chk("cnt0_q", 32'(q), 32'h0C);
    chk("cnt0_busy", 32'(busy), 32'h0);
    chk("cnt0_done", 32'(done), 32'h1);
    count = 4'd1; sin0 = 1'b1; tick();
    chk("cnt1_q", 32'(q), 32'h86);
    chk("cnt1_busy", 32'(busy), 32'h0);
    chk("cnt1_done", 32'(done), 32'h1);
    start = 1'b0; op = 2'b11; tick();
    chk("cnt1_after", 32'(done), 32'h0);

    // Back-to-back bursts: new start in the done cycle.
    op = 2'b10; sinN = 1'b1; start = 1'b1; count = 4'd2; tick();
    start = 1'b0; tick();
    chk("b2b_done", 32'(done), 32'h1);
    op = 2'b01; start = 1'b1; count = 4'd3; tick();
    chk("b2b_busy", 32'(busy), 32'h1);
    idle();
    repeat (3) tick();

`ifdef UNIV_SHIFT_ARITH_EN
    op = 2'b00; d = 8'hC0; tick();
    op = 2'b01; arith = 1'b1; start = 1'b1; count = 4'd3; tick();
    start = 1'b0; arith = 1'b0; op = 2'b11; tick(); tick();
    chk("ar_q", 32'(q), 32'hF8);
    chk("ar_ovf0", 32'(ovf), 32'h0);
    op = 2'b00; d = 8'h40; tick();
    op = 2'b10; arith = 1'b1; start = 1'b1; count = 4'd1; tick();
    chk("ar_qn", 32'(q), 32'h80);
    chk("ar_ovf1", 32'(ovf), 32'h1);
    idle();
    op = 2'b00; tick();
    chk("ar_ovf_clr", 32'(ovf), 32'h0);
    idle();
`endif

    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      op    = 2'($urandom_range(0, 3));
      d     = 8'($urandom);
      sin0  = 1'($urandom);
      sinN  = 1'($urandom);
      rot   = ($urandom_range(0, 2) == 0);
      start = ($urandom_range(0, 2) == 0);
      count = 4'($urandom_range(0, 15));
`ifdef UNIV_SHIFT_ARITH_EN
      arith = 1'($urandom);
`else
      arith = 1'b0;
`endif
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
